// File: rtl/vx_tex_filter_if.sv
// Request/response bundle of the texture filter: texel-format stage drives req_*, tex response path consumes rsp_*.
interface vx_tex_filter_if #(
    parameter int NUM_LANES    = 4,
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_BITS    = 8,
    parameter int BLEND_FRAC   = 8,
    parameter int REQ_INFOW    = 1
);
    localparam int TW = NUM_CHANNELS * CHAN_BITS;

    logic                                req_valid;
    logic [1:0]                          req_mode;
    logic [NUM_LANES-1:0]                req_mask;
    logic [NUM_LANES*2*BLEND_FRAC-1:0]   req_blends;
    logic [NUM_LANES*4*TW-1:0]           req_data;
    logic [REQ_INFOW-1:0]                req_info;
    logic                                req_ready;

    logic                                rsp_valid;
    logic [NUM_LANES-1:0]                rsp_mask;
    logic [NUM_LANES*TW-1:0]             rsp_data;
    logic [REQ_INFOW-1:0]                rsp_info;
    logic                                rsp_ready;

    modport master (
        output req_valid, req_mode, req_mask, req_blends, req_data, req_info,
        input  req_ready,
        input  rsp_valid, rsp_mask, rsp_data, rsp_info,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_mode, req_mask, req_blends, req_data, req_info,
        output req_ready,
        output rsp_valid, rsp_mask, rsp_data, rsp_info,
        input  rsp_ready
    );
endinterface

// File: rtl/vx_tex_filter.sv
// Per-lane point / linear-U / bilinear texel filter: fixed-latency non-stalling lerp pipeline
// feeding a first-word-fall-through output FIFO whose occupancy is reserved by credits at accept.
module vx_tex_filter #(
    parameter string INSTANCE_ID  = "",
    parameter int    NUM_LANES    = 4,
    parameter int    NUM_CHANNELS = 4,
    parameter int    CHAN_BITS    = 8,
    parameter int    BLEND_FRAC   = 8,
    parameter int    LERP_LATENCY = 3,
    parameter int    REQ_INFOW    = 1,
    parameter int    OUT_BUF      = 9
) (
    input  logic             clk,
    input  logic             reset,
    vx_tex_filter_if.slave   io_tex
);
    localparam int TW  = NUM_CHANNELS * CHAN_BITS;
    localparam int F   = BLEND_FRAC;
    localparam int L   = LERP_LATENCY;
    localparam int LW  = NUM_LANES * TW;
    localparam int BW  = NUM_LANES * F;
    localparam int IW  = CHAN_BITS + F + 1;
    localparam int CW  = $clog2(OUT_BUF + 1);
    localparam int PW  = (OUT_BUF > 1) ? $clog2(OUT_BUF) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(OUT_BUF);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUT_BUF - 1);

    if (LERP_LATENCY < 1 || OUT_BUF < 1) begin : g_bad_param
        $error("vx_tex_filter %s: LERP_LATENCY and OUT_BUF must be >= 1", INSTANCE_ID);
    end

    // Rounded lerp; weight (2^F - f) needs F+1 bits, the sum never exceeds CHAN_BITS+F+1 bits.
    function automatic logic [CHAN_BITS-1:0] f_lerp(input logic [CHAN_BITS-1:0] a,
                                                    input logic [CHAN_BITS-1:0] b,
                                                    input logic [F-1:0]         f);
        logic [IW-1:0] w_a, w_b, w_f, w_fi, w_sum;
        w_a   = IW'(a);
        w_b   = IW'(b);
        w_f   = IW'(f);
        w_fi  = (IW'(1) << F) - w_f;
        w_sum = w_a * w_fi + w_b * w_f + (IW'(1) << (F - 1));
        return w_sum[F +: CHAN_BITS];
    endfunction

    function automatic logic [TW-1:0] f_lerp_texel(input logic [TW-1:0] a,
                                                   input logic [TW-1:0] b,
                                                   input logic [F-1:0]  f);
        logic [TW-1:0] w_r;
        w_r = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            w_r[c*CHAN_BITS +: CHAN_BITS] = f_lerp(a[c*CHAN_BITS +: CHAN_BITS], b[c*CHAN_BITS +: CHAN_BITS], f);
        return w_r;
    endfunction

    logic [CW-1:0] r_credits;
    logic [CW-1:0] r_fifo_cnt;
    logic          w_req_ready, w_accept, w_fire, w_push, w_fifo_empty;

    assign w_req_ready      = (r_credits < MAX_CNT);
    assign io_tex.req_ready = w_req_ready;
    assign w_accept         = io_tex.req_valid & w_req_ready;
    assign w_fifo_empty     = (r_fifo_cnt == '0);
    assign w_fire           = ~w_fifo_empty & io_tex.rsp_ready;

    // Mode handling folds into the weights: point zeroes u and v, linear-U zeroes v.
    logic [BW-1:0]             w_u_in, w_v_in;
    logic [NUM_LANES*4*TW-1:0] w_tex_in;
    always_comb begin
        w_u_in   = '0;
        w_v_in   = '0;
        w_tex_in = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (io_tex.req_mode != 2'd0)
                w_u_in[l*F +: F] = io_tex.req_blends[l*2*F +: F];
            if (io_tex.req_mode[1])
                w_v_in[l*F +: F] = io_tex.req_blends[l*2*F + F +: F];
            if (io_tex.req_mask[l])
                w_tex_in[l*4*TW +: 4*TW] = io_tex.req_data[l*4*TW +: 4*TW];
        end
    end

    logic                      r_s0_valid;
    logic [NUM_LANES-1:0]      r_s0_mask;
    logic [REQ_INFOW-1:0]      r_s0_info;
    logic [BW-1:0]             r_s0_u, r_s0_v;
    logic [NUM_LANES*4*TW-1:0] r_s0_tex;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_mask  <= '0;
            r_s0_info  <= '0;
            r_s0_u     <= '0;
            r_s0_v     <= '0;
            r_s0_tex   <= '0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_mask <= io_tex.req_mask;
                r_s0_info <= io_tex.req_info;
                r_s0_u    <= w_u_in;
                r_s0_v    <= w_v_in;
                r_s0_tex  <= w_tex_in;
            end
        end
    end

    logic [LW-1:0] w_u_lo, w_u_hi;
    always_comb begin
        w_u_lo = '0;
        w_u_hi = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_u_lo[l*TW +: TW] = f_lerp_texel(r_s0_tex[l*4*TW +: TW], r_s0_tex[l*4*TW + TW +: TW], r_s0_u[l*F +: F]);
            w_u_hi[l*TW +: TW] = f_lerp_texel(r_s0_tex[l*4*TW + 2*TW +: TW], r_s0_tex[l*4*TW + 3*TW +: TW], r_s0_u[l*F +: F]);
        end
    end

    logic [L-1:0]                      r_u_valid;
    logic [L-1:0][NUM_LANES-1:0]       r_u_mask;
    logic [L-1:0][REQ_INFOW-1:0]       r_u_info;
    logic [L-1:0][BW-1:0]              r_u_v;
    logic [L-1:0][LW-1:0]              r_u_lo, r_u_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_u_valid <= '0;
            r_u_mask  <= '0;
            r_u_info  <= '0;
            r_u_v     <= '0;
            r_u_lo    <= '0;
            r_u_hi    <= '0;
        end else begin
            r_u_valid[0] <= r_s0_valid;
            r_u_mask[0]  <= r_s0_mask;
            r_u_info[0]  <= r_s0_info;
            r_u_v[0]     <= r_s0_v;
            r_u_lo[0]    <= w_u_lo;
            r_u_hi[0]    <= w_u_hi;
            for (int i = 1; i < L; i++) begin
                r_u_valid[i] <= r_u_valid[i-1];
                r_u_mask[i]  <= r_u_mask[i-1];
                r_u_info[i]  <= r_u_info[i-1];
                r_u_v[i]     <= r_u_v[i-1];
                r_u_lo[i]    <= r_u_lo[i-1];
                r_u_hi[i]    <= r_u_hi[i-1];
            end
        end
    end

    logic [LW-1:0] w_v_res;
    always_comb begin
        w_v_res = '0;
        for (int l = 0; l < NUM_LANES; l++)
            w_v_res[l*TW +: TW] = f_lerp_texel(r_u_lo[L-1][l*TW +: TW], r_u_hi[L-1][l*TW +: TW], r_u_v[L-1][l*F +: F]);
    end

    logic [L-1:0]                r_v_valid;
    logic [L-1:0][NUM_LANES-1:0] r_v_mask;
    logic [L-1:0][REQ_INFOW-1:0] r_v_info;
    logic [L-1:0][LW-1:0]        r_v_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_valid <= '0;
            r_v_mask  <= '0;
            r_v_info  <= '0;
            r_v_data  <= '0;
        end else begin
            r_v_valid[0] <= r_u_valid[L-1];
            r_v_mask[0]  <= r_u_mask[L-1];
            r_v_info[0]  <= r_u_info[L-1];
            r_v_data[0]  <= w_v_res;
            for (int i = 1; i < L; i++) begin
                r_v_valid[i] <= r_v_valid[i-1];
                r_v_mask[i]  <= r_v_mask[i-1];
                r_v_info[i]  <= r_v_info[i-1];
                r_v_data[i]  <= r_v_data[i-1];
            end
        end
    end

    assign w_push = r_v_valid[L-1];

    logic [NUM_LANES-1:0] r_mem_mask [OUT_BUF];
    logic [REQ_INFOW-1:0] r_mem_info [OUT_BUF];
    logic [LW-1:0]        r_mem_data [OUT_BUF];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_mask[r_wr_ptr] <= r_v_mask[L-1];
            r_mem_info[r_wr_ptr] <= r_v_info[L-1];
            r_mem_data[r_wr_ptr] <= r_v_data[L-1];
        end
    end

    // Credits are taken at accept, so a push can never land on a full FIFO unless a pop happens too.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_credits  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            if (w_fire)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_fire})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_fire})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign io_tex.rsp_valid = ~w_fifo_empty;
    assign io_tex.rsp_mask  = w_fifo_empty ? '0 : r_mem_mask[r_rd_ptr];
    assign io_tex.rsp_info  = w_fifo_empty ? '0 : r_mem_info[r_rd_ptr];
    assign io_tex.rsp_data  = w_fifo_empty ? '0 : r_mem_data[r_rd_ptr];

endmodule

// File: tb/tb_vx_tex_filter.sv
// Directed bench for vx_tex_filter: filter modes, masking, latency, credits/backpressure, throughput, reset.
module tb_vx_tex_filter;
    localparam int NL = 4;
    localparam int TW = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vx_tex_filter_if #(.NUM_LANES(4), .NUM_CHANNELS(4), .CHAN_BITS(8), .BLEND_FRAC(8), .REQ_INFOW(1)) bif ();

    vx_tex_filter #(
        .INSTANCE_ID("tb"), .NUM_LANES(4), .NUM_CHANNELS(4), .CHAN_BITS(8), .BLEND_FRAC(8),
        .LERP_LATENCY(3), .REQ_INFOW(1), .OUT_BUF(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_tex(bif)
    );

    function automatic logic [31:0] lane_out(input int l);
        return bif.rsp_data[l*TW +: TW];
    endfunction

    task automatic clear_req();
        bif.req_valid  = 1'b0;
        bif.req_mode   = 2'd0;
        bif.req_mask   = '0;
        bif.req_blends = '0;
        bif.req_data   = '0;
        bif.req_info   = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] t0, input logic [31:0] t1,
                            input logic [31:0] t2, input logic [31:0] t3,
                            input logic [7:0] u, input logic [7:0] v);
        bif.req_data[l*128 +: 32]      = t0;
        bif.req_data[l*128 + 32 +: 32] = t1;
        bif.req_data[l*128 + 64 +: 32] = t2;
        bif.req_data[l*128 + 96 +: 32] = t3;
        bif.req_blends[l*16 +: 8]      = u;
        bif.req_blends[l*16 + 8 +: 8]  = v;
    endtask

    // Called just after a rising edge; returns at the falling edge of the response cycle.
    task automatic send_one(input logic [1:0] mode, input logic [3:0] mask, input logic info, output int lat);
        bif.req_mode  = mode;
        bif.req_mask  = mask;
        bif.req_info  = info;
        bif.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bif.rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_req();
        bif.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", bif.rsp_valid); end
        checks++; if (bif.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bif.rsp_data); end
        checks++; if (bif.rsp_mask !== 4'h0) begin errors++; $display("FAIL reset_rsp_mask: got %h expected 0", bif.rsp_mask); end
        checks++; if (bif.rsp_info !== 1'b0) begin errors++; $display("FAIL reset_rsp_info: got %0b expected 0", bif.rsp_info); end
        checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b expected 1", bif.req_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_point();
        int lat;
        clear_req();
        bif.rsp_ready = 1'b1;
        set_lane(0, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80, 8'h80);
        set_lane(1, 32'h55667788, 32'h00000000, 32'h00000000, 32'h00000000, 8'hFF, 8'hFF);
        set_lane(2, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 8'h40, 8'h40);
        set_lane(3, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 8'h10, 8'h20);
        send_one(2'd0, 4'b0011, 1'b1, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL point_latency: got %0d expected 8", lat); end
        checks++; if (lane_out(0) !== 32'h11223344) begin errors++; $display("FAIL point_lane0: got %h expected 11223344", lane_out(0)); end
        checks++; if (lane_out(1) !== 32'h55667788) begin errors++; $display("FAIL point_lane1: got %h expected 55667788", lane_out(1)); end
        checks++; if (lane_out(2) !== 32'h0) begin errors++; $display("FAIL point_masked_lane2: got %h expected 0", lane_out(2)); end
        checks++; if (lane_out(3) !== 32'h0) begin errors++; $display("FAIL point_masked_lane3: got %h expected 0", lane_out(3)); end
        checks++; if (bif.rsp_mask !== 4'b0011) begin errors++; $display("FAIL point_mask: got %b expected 0011", bif.rsp_mask); end
        checks++; if (bif.rsp_info !== 1'b1) begin errors++; $display("FAIL point_info: got %0b expected 1", bif.rsp_info); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_linear();
        int lat;
        clear_req();
        bif.rsp_ready = 1'b1;
        set_lane(0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80, 8'hFF);
        set_lane(1, 32'h01020304, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 8'h00, 8'h00);
        set_lane(2, 32'h10101010, 32'h20202020, 32'h00000000, 32'h00000000, 8'h40, 8'h80);
        set_lane(3, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 8'hFF, 8'h00);
        send_one(2'd1, 4'b1111, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL linear_latency: got %0d expected 8", lat); end
        checks++; if (lane_out(0) !== 32'h80808080) begin errors++; $display("FAIL linear_half: got %h expected 80808080", lane_out(0)); end
        checks++; if (lane_out(1) !== 32'h01020304) begin errors++; $display("FAIL linear_u0: got %h expected 01020304", lane_out(1)); end
        checks++; if (lane_out(2) !== 32'h14141414) begin errors++; $display("FAIL linear_quarter: got %h expected 14141414", lane_out(2)); end
        checks++; if (lane_out(3) !== 32'h01010101) begin errors++; $display("FAIL linear_uff: got %h expected 01010101", lane_out(3)); end
        checks++; if (bif.rsp_info !== 1'b0) begin errors++; $display("FAIL linear_info: got %0b expected 0", bif.rsp_info); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bilinear();
        int lat;
        clear_req();
        bif.rsp_ready = 1'b1;
        for (int l = 0; l < NL; l++)
            set_lane(l, 32'h00000000, 32'h40404040, 32'h80808080, 32'hC0C0C0C0, 8'h80, 8'h80);
        send_one(2'd2, 4'b0101, 1'b1, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL bilinear_latency: got %0d expected 8", lat); end
        checks++; if (lane_out(0) !== 32'h60606060) begin errors++; $display("FAIL bilinear_lane0: got %h expected 60606060", lane_out(0)); end
        checks++; if (lane_out(1) !== 32'h0) begin errors++; $display("FAIL bilinear_masked1: got %h expected 0", lane_out(1)); end
        checks++; if (lane_out(2) !== 32'h60606060) begin errors++; $display("FAIL bilinear_lane2: got %h expected 60606060", lane_out(2)); end
        checks++; if (lane_out(3) !== 32'h0) begin errors++; $display("FAIL bilinear_masked3: got %h expected 0", lane_out(3)); end
        checks++; if (bif.rsp_mask !== 4'b0101) begin errors++; $display("FAIL bilinear_mask: got %b expected 0101", bif.rsp_mask); end
        @(posedge clk);
        #1;
        set_lane(1, 32'h10101010, 32'h30303030, 32'h50505050, 32'h70707070, 8'h40, 8'hC0);
        send_one(2'd3, 4'b1111, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL mode3_latency: got %0d expected 8", lat); end
        checks++; if (lane_out(1) !== 32'h48484848) begin errors++; $display("FAIL mode3_lane1: got %h expected 48484848", lane_out(1)); end
        checks++; if (lane_out(3) !== 32'h60606060) begin errors++; $display("FAIL mode3_lane3: got %h expected 60606060", lane_out(3)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int   tx;
        int   rx;
        int   first;
        logic rdy;
        tx = 0;
        rx = 0;
        first = -1;
        clear_req();
        bif.rsp_ready = 1'b1;
        bif.req_mode  = 2'd0;
        bif.req_mask  = 4'b0001;
        for (int c = 0; c < 130; c++) begin
            if (tx < 100) begin
                bif.req_valid = 1'b1;
                set_lane(0, 32'(tx), 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
                bif.req_info = tx[0];
            end else begin
                bif.req_valid = 1'b0;
            end
            @(negedge clk);
            rdy = bif.req_ready;
            if (tx < 100) begin
                checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_req_ready: cycle %0d got %0b expected 1", c, rdy); end
            end
            if (bif.rsp_valid === 1'b1) begin
                if (first < 0) first = c;
                checks++;
                if (lane_out(0) !== 32'(rx) || bif.rsp_info !== rx[0] || c != first + rx) begin
                    errors++;
                    $display("FAIL b2b_order: cycle %0d got tag %0d expected %0d (first %0d)", c, lane_out(0), rx, first);
                end
                rx++;
            end
            @(posedge clk);
            #1;
            if (tx < 100 && rdy === 1'b1) tx++;
        end
        checks++; if (first !== 8) begin errors++; $display("FAIL b2b_first: got %0d expected 8", first); end
        checks++; if (rx !== 100) begin errors++; $display("FAIL b2b_count: got %0d expected 100", rx); end
    endtask

    task automatic test_backpressure();
        int   acc;
        logic rdy;
        acc = 0;
        clear_req();
        bif.rsp_ready = 1'b0;
        bif.req_mode  = 2'd0;
        bif.req_mask  = 4'b0001;
        bif.req_valid = 1'b1;
        set_lane(0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rdy = bif.req_ready;
            @(posedge clk);
            if (rdy === 1'b1) acc++;
            #1;
            set_lane(0, 32'(acc), 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
            bif.req_info = acc[0];
        end
        checks++; if (acc !== 9) begin errors++; $display("FAIL bp_accepts: got %0d expected 9", acc); end
        @(negedge clk);
        checks++; if (bif.req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b expected 0", bif.req_ready); end
        checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %0b expected 1", bif.rsp_valid); end
        @(posedge clk);
        #1;
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bif.req_ready !== 1'b0) begin errors++; $display("FAIL bp_comb_path: got %0b expected 0", bif.req_ready); end
        checks++; if (lane_out(0) !== 32'd0) begin errors++; $display("FAIL bp_drain0: got %0d expected 0", lane_out(0)); end
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %0b expected 1", bif.req_ready); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (bif.rsp_valid !== 1'b1 || lane_out(0) !== 32'(k)) begin
                errors++;
                $display("FAIL bp_drain: valid %0b tag %0d expected tag %0d", bif.rsp_valid, lane_out(0), k);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", bif.rsp_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int stale;
        int lat;
        stale = 0;
        clear_req();
        bif.rsp_ready = 1'b0;
        bif.req_mode  = 2'd0;
        bif.req_mask  = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                bif.req_valid = 1'b1;
                set_lane(0, 32'h100 + 32'(c), 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
            end else begin
                bif.req_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 9) begin
                checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_buffered: got %0b expected 1", bif.rsp_valid); end
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", bif.rsp_valid); end
        checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b expected 1", bif.req_ready); end
        checks++; if (bif.rsp_data !== '0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", bif.rsp_data); end
        @(posedge clk);
        #1;
        bif.rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bif.rsp_valid === 1'b1) stale++;
            @(posedge clk);
            #1;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d responses expected 0", stale); end
        set_lane(0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
        send_one(2'd0, 4'b0001, 1'b1, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rstmid_latency: got %0d expected 8", lat); end
        checks++; if (lane_out(0) !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_data_after: got %h expected cafef00d", lane_out(0)); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_point();
        test_linear();
        test_bilinear();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_tex_filter.md
Name: VX_tex_filter

Overview:
- Parametrised next-generation texture filter for the tex unit: per-lane point, linear-U or bilinear filtering of four pre-formatted texels, with configurable channel count and width, blend precision and lerp latency.
- Sits between the texel-fetch/format stage and the tex response path.
- Uses a fixed-latency, never-stalling datapath plus a credit-gated output FIFO, so `req_ready` has no combinational dependence on `rsp_ready`.

Parameters:
- INSTANCE_ID, "", trace tag.
- NUM_LANES, 4, lanes per request.
- NUM_CHANNELS, 4, channels per texel.
- CHAN_BITS, 8, bits per channel; texel width TW = NUM_CHANNELS*CHAN_BITS.
- BLEND_FRAC, 8, fraction bits F of u/v blend weights.
- LERP_LATENCY, 3, register stages per lerp level (>=1).
- REQ_INFOW, 1, opaque tag width.
- OUT_BUF, 9, output FIFO depth and credit count (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_mode  in  2  0=point, 1=linear-U, 2=bilinear, 3=reserved (treated as bilinear)
- req_mask  in  NUM_LANES  active lanes
- req_blends  in  NUM_LANES*2*F  per lane [0]=u, [1]=v fraction
- req_data  in  NUM_LANES*4*TW  per lane texels t0..t3
- req_info  in  REQ_INFOW  tag
- req_ready  out  1  request accepted when high with req_valid
- rsp_valid  out  1  response valid
- rsp_mask  out  NUM_LANES  echoed req_mask
- rsp_data  out  NUM_LANES*TW  filtered texel per lane
- rsp_info  out  REQ_INFOW  echoed tag
- rsp_ready  in  1  consumer ready

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Lerp per channel: lerp(a,b,f) = (a*(2^F - f) + b*f + 2^(F-1)) >> F.
  - Intermediate width CHAN_BITS+F+1; no overflow.
  - f=0 returns a exactly; result never exceeds max(a,b).
- Modes:
  - Point: out = t0. Both fracs are forced to 0 internally.
  - Linear-U: out = lerp(t0,t1,u). v is forced to 0.
  - Bilinear: out = lerp(lerp(t0,t1,u), lerp(t2,t3,u), v).
  - Every mode has identical latency.
- Masked lanes: rsp_data lane is 0 regardless of inputs.
- Pipeline:
  - Stage 0 is the input register, loaded on accept.
  - Then LERP_LATENCY stages of U lerp, then LERP_LATENCY stages of V lerp, then FIFO write.
  - Valid, info, mask and the delayed v shift alongside the data. The pipeline enable is always 1 and it never stalls.
  - PIPE_LAT = 2 + 2*LERP_LATENCY (8 by default): a request accepted on the edge ending cycle 0 produces rsp_valid in cycle PIPE_LAT when the FIFO was empty.
- Credits:
  - count = in-flight + buffered entries, range 0..OUT_BUF.
  - req_ready = (count < OUT_BUF), driven from registered state only.
  - Accept only: +1. Response fire (rsp_valid & rsp_ready) only: -1. Both in the same cycle: unchanged.
  - The FIFO therefore never overflows and no data is dropped.
- Output FIFO:
  - First-word-fall-through; rsp_* come from the FIFO head.
  - Write and read on the same cycle while full is legal (credits guarantee no overflow).
  - Read while empty is impossible because rsp_valid = 0.
  - Responses leave in acceptance order.
- Throughput: one request per cycle sustained iff OUT_BUF >= PIPE_LAT+1 and rsp_ready is held high. Otherwise issue rate is bounded by credits.
- Reset:
  - count=0, FIFO empty, all pipeline valids 0.
  - rsp_valid=0; rsp_data, rsp_mask and rsp_info are 0.
  - req_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight and buffered requests; no response ever emerges for them.
- Trace (DBG_TRACE_TEX): log each accepted request (mode, mask, blends, texels) and each fired response (data, tag uuid).

Test Plan:
- Basic point mode:
  - Stimulus: mode=0, lane0 t0=0x11223344, t1..t3=0xFFFFFFFF, u=v=0x80, rsp_ready=1.
  - Response: rsp_data lane0=0x11223344 with rsp_valid exactly 8 cycles after accept.
- Linear-U rounding:
  - Stimulus: mode=1, t0=0x00000000, t1=0xFFFFFFFF, u=0x80.
  - Response: lane = 0x80808080 (255*128+128)>>8=128; with u=0x00 the lane equals t0.
- Bilinear:
  - Stimulus: mode=2, t0=0x00, t1=0x40, t2=0x80, t3=0xC0 (all channels), u=v=0x80.
  - Response: U results 0x20/0xA0, final 0x60 per channel, i.e. 0x60606060. Lanes with mask bit 0 output 0 and rsp_mask echoes the mask.
- Backpressure and credits:
  - Stimulus: rsp_ready=0, req_valid held high.
  - Response: exactly OUT_BUF=9 accepts, then req_ready=0 with no combinational path from rsp_ready.
  - Then raise rsp_ready: all 9 tags drain in order, and req_ready returns the cycle after the first fire.
- Full throughput: 100 back-to-back requests with rsp_ready=1 and incrementing tags -> 100 consecutive rsp_valid cycles, tags 0..99 in order, with no bubbles after the initial 8.
- Reset mid-operation:
  - Stimulus: 5 requests in flight and 3 buffered, then pulse reset for 1 cycle.
  - Response: rsp_valid=0 from the cycle after reset, req_ready=1, no stale responses; a new request then completes normally with latency 8.
